calc_core_p: RTL and testbench
==============================

# calc_core_p

Parametrised successor to the 16-bit calculator controller. Accepts BCD keypad digits, a one-hot operator, negate, clear and equal keys, and builds two signed operands. It computes add, subtract or multiply at a configurable width, then presents the result with completion and overflow status. It sits between the keypad scanner/debouncer and the display driver.

## Interface
- WIDTH, 16: operand/result width in bits, signed two's complement, range 4..32.
- clk  in  1  system clock, all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- keypad_input  in  4  BCD digit; values 10..15 are ignored.
- read_input  in  1  digit strobe; one digit is accepted per rising edge (internal edge detect).
- operator_input  in  3  one-hot level: 001 add, 010 subtract, 100 multiply. 000 or non-one-hot means no operator.
- equal_input  in  1  level; requests computation.
- negate_input  in  1  rising-edge sensitive; toggles sign of the operand being entered.
- clear_input  in  1  level; synchronous clear.
- complete  out  1  high while in DONE.
- busy  out  1  high while in COMPUTE.
- overflow  out  1  sticky until clear or new entry; set on entry overflow or result overflow.
- display_output  out  WIDTH  signed operand under entry, or the result in DONE.

## Operation
- States: ENTRY_A, ENTRY_B, COMPUTE, DONE. Reset and clear go to ENTRY_A.
- ENTRY_A/ENTRY_B, accepted digit d:
  - Magnitude becomes mag*10+d, computed in WIDTH+4 bits.
  - If the new magnitude exceeds 2^(WIDTH-1)-1, the digit is rejected, mag is unchanged and overflow is set.
- Negate edge in an entry state toggles that operand's sign flag. Display shows sign applied to magnitude; -0 displays 0.
- ENTRY_A, valid one-hot operator: latch op, clear the B operand, go to ENTRY_B. Operator level held in ENTRY_B is ignored; the op latched at the transition stands.
- ENTRY_B, equal_input=1: go to COMPUTE; operand B may be 0 (no digits pressed).
- COMPUTE:
  - Add/sub take 1 cycle, exact result in WIDTH+1 bits.
  - Multiply takes WIDTH cycles of shift-add on magnitudes in 2*WIDTH bits; sign = sA XOR sB, applied in the final cycle.
- Result overflow: exact result outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] sets overflow. The stored value is governed by CALC_SAT_EN.
- DONE:
  - complete=1 and the result is displayed. Equal held high does not retrigger.
  - Digit edge: start a new ENTRY_A with this digit as the first; overflow clears.
  - Valid operator: chain. Result becomes operand A (full range, including the minimum value), go to ENTRY_B.
- Priority within a cycle: clear > equal > operator > negate > digit.

## Timing
- Reset values: display_output 0, complete 0, busy 0, overflow 0, state ENTRY_A, both operands +0, op none.
- Digit: read_input rising at cycle N updates display_output at N+1.
- Add/sub: equal sampled at N, COMPUTE at N+1, complete and result valid at N+2.
- Multiply: equal sampled at N, busy high N+1..N+WIDTH, complete at N+WIDTH+1.
- clear_input sampled at N: all outputs reach reset values at N+1, including mid-multiply (multiplier aborted).
- nRST asserted at any time forces reset values immediately.

## Configuration
- CALC_SAT_EN defined: an overflowed result saturates to 2^(WIDTH-1)-1 or -2^(WIDTH-1) according to the sign of the exact result.
- CALC_SAT_EN undefined: an overflowed result wraps to its low WIDTH bits.
- overflow is set identically in both builds.

## Structure
- Package calc_pkg holds:
  - state_t enum {ENTRY_A, ENTRY_B, COMPUTE, DONE}
  - op_t enum {OP_NONE, OP_ADD, OP_SUB, OP_MUL}
  - one-hot encodings OP_ADD_OH=3'b001, OP_SUB_OH=3'b010, OP_MUL_OH=3'b100
  - BCD_MAX=9
- Sub-module calc_mult_seq, parametrised on WIDTH:
  - Inputs: start, magnitudes, abort. Outputs: done, 2*WIDTH product.
  - Sign handling and overflow/saturation stay in calc_core_p.

## Test plan
- WIDTH=16: digits 1,1; op 001; digits 2,3; equal. Expect display 34, complete two cycles after equal, overflow 0.
- Digit 4; op 100; digit 3; negate; equal. Expect -12 (16'hFFF4), complete at equal+17.
- 200*200: overflow=1. CALC_SAT_EN build displays 32767; wrap build displays 16'h9C40 (-25536).
- Digits 3,2,7,6,7,1: display holds 32767 after the fifth digit, the sixth is rejected, overflow=1.
- Clear asserted 5 cycles into a multiply: next cycle busy=0, complete=0, display 0, state ENTRY_A. A following 2+3 returns 5.
- WIDTH=8 build: 100+27=127 with no overflow; then chain op 001 and digit 1 gives 127+1, overflow=1, display 127 (sat) or -128 (wrap).

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the parametrised keypad calculator core.
// Used by calc_core_p and its sequential multiplier.
package calc_pkg;

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, COMPUTE, DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  localparam logic [2:0] OP_ADD_OH = 3'b001;
  localparam logic [2:0] OP_SUB_OH = 3'b010;
  localparam logic [2:0] OP_MUL_OH = 3'b100;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Anything other than exactly one hot bit means "no operator".
  function automatic op_t decode_op(input logic [2:0] oh);
    case (oh)
      OP_ADD_OH: return OP_ADD;
      OP_SUB_OH: return OP_SUB;
      OP_MUL_OH: return OP_MUL;
      default:   return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_mult_seq.sv
// Unsigned shift-add multiplier: WIDTH steps after start, product and done are
// presented combinationally during the last step so the caller can capture them.
module calc_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic                 running;
  logic [CW-1:0]        step;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;

  // NOTE: assign a default first in always_comb so no path leaves acc_next unassigned (no latch).
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign done    = running && (step == LAST);
  assign product = acc_next;

  // NOTE: the datapath registers are reset along with the control so nothing downstream sees X.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      running <= 1'b0;
      step    <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a_mag};
      mplier  <= b_mag;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_core_p.sv
// Keypad calculator core: sign/magnitude operand entry, add/sub/mul, chaining.
// Define CALC_SAT_EN to saturate overflowed results; otherwise they wrap.
module calc_core_p
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [3:0]        keypad_input,
  input  logic              read_input,
  input  logic [2:0]        operator_input,
  input  logic              equal_input,
  input  logic              negate_input,
  input  logic              clear_input,
  output logic              complete,
  output logic              busy,
  output logic              overflow,
  output logic [WIDTH-1:0]  display_output
);

  localparam int               XW      = 2*WIDTH + 1;
  localparam logic [WIDTH+3:0] MAG_MAX = {5'b0, {(WIDTH-1){1'b1}}};

  state_t               state;
  op_t                  op;
  op_t                  op_in;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 a_neg, b_neg;
  logic                 read_q, negate_q;
  logic                 digit_valid, negate_edge;
  logic [WIDTH-1:0]     base_mag, digit_mag;
  logic [WIDTH+3:0]     new_mag;
  logic                 digit_ovf;
  logic signed [WIDTH-1:0] a_val, b_val;
  logic signed [WIDTH:0]   addsub_exact;
  logic [XW-1:0]        mul_pos, exact;
  logic [WIDTH+1:0]     exact_hi;
  logic                 res_ovf;
  logic [WIDTH-1:0]     res_val;
  logic                 mult_start, mult_done;
  logic [2*WIDTH-1:0]   mult_product;

  // Negation of a magnitude; applied to a signed value it yields |x|.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  assign digit_valid = read_input && !read_q && (keypad_input <= BCD_MAX);
  assign negate_edge = negate_input && !negate_q;
  assign op_in       = decode_op(operator_input);

  // A digit arriving in DONE starts a fresh operand, hence the zero base there.
  always_comb begin
    base_mag = '0;
    case (state)
      ENTRY_A: base_mag = a_mag;
      ENTRY_B: base_mag = b_mag;
      default: base_mag = '0;
    endcase
  end

  assign new_mag   = {4'b0, base_mag} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, keypad_input};
  assign digit_ovf = new_mag > MAG_MAX;
  assign digit_mag = new_mag[WIDTH-1:0];

  assign a_val = apply_sign(a_mag, a_neg);
  assign b_val = apply_sign(b_mag, b_neg);
  assign addsub_exact = (op == OP_SUB) ? ({a_val[WIDTH-1], a_val} - {b_val[WIDTH-1], b_val})
                                       : ({a_val[WIDTH-1], a_val} + {b_val[WIDTH-1], b_val});
  assign mul_pos = {1'b0, mult_product};

  always_comb begin
    exact = {{WIDTH{addsub_exact[WIDTH]}}, addsub_exact};
    if (op == OP_MUL) exact = (a_neg ^ b_neg) ? -mul_pos : mul_pos;
  end

  // The exact result fits iff every bit from the result sign upwards agrees.
  assign exact_hi = exact[XW-1:WIDTH-1];
  assign res_ovf  = !((&exact_hi) || !(|exact_hi));

`ifdef CALC_SAT_EN
  assign res_val = !res_ovf        ? exact[WIDTH-1:0] :
                   exact[XW-1]     ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_val = exact[WIDTH-1:0];
`endif

  assign mult_start = !clear_input && (state == ENTRY_B) && equal_input && (op == OP_MUL);

  calc_mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .nRST    (nRST),
    .start   (mult_start),
    .abort   (clear_input),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .done    (mult_done),
    .product (mult_product)
  );

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state          <= ENTRY_A;
      op             <= OP_NONE;
      a_mag          <= '0;
      a_neg          <= 1'b0;
      b_mag          <= '0;
      b_neg          <= 1'b0;
      read_q         <= 1'b0;
      negate_q       <= 1'b0;
      complete       <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      display_output <= '0;
    end else begin
      read_q   <= read_input;
      negate_q <= negate_input;
      if (clear_input) begin
        state          <= ENTRY_A;
        op             <= OP_NONE;
        a_mag          <= '0;
        a_neg          <= 1'b0;
        b_mag          <= '0;
        b_neg          <= 1'b0;
        complete       <= 1'b0;
        busy           <= 1'b0;
        overflow       <= 1'b0;
        display_output <= '0;
      end else begin
        case (state)
          ENTRY_A: begin
            if (op_in != OP_NONE) begin
              op             <= op_in;
              b_mag          <= '0;
              b_neg          <= 1'b0;
              display_output <= '0;
              state          <= ENTRY_B;
            end else if (negate_edge) begin
              a_neg          <= !a_neg;
              display_output <= apply_sign(a_mag, !a_neg);
            end else if (digit_valid) begin
              if (digit_ovf) begin
                overflow <= 1'b1;
              end else begin
                a_mag          <= digit_mag;
                display_output <= apply_sign(digit_mag, a_neg);
              end
            end
          end
          ENTRY_B: begin
            if (equal_input) begin
              busy  <= 1'b1;
              state <= COMPUTE;
            end else if (negate_edge) begin
              b_neg          <= !b_neg;
              display_output <= apply_sign(b_mag, !b_neg);
            end else if (digit_valid) begin
              if (digit_ovf) begin
                overflow <= 1'b1;
              end else begin
                b_mag          <= digit_mag;
                display_output <= apply_sign(digit_mag, b_neg);
              end
            end
          end
          COMPUTE: begin
            if (op != OP_MUL || mult_done) begin
              display_output <= res_val;
              overflow       <= overflow | res_ovf;
              busy           <= 1'b0;
              complete       <= 1'b1;
              state          <= DONE;
            end
          end
          DONE: begin
            // The displayed result is the chained A operand, minimum value included.
            if (op_in != OP_NONE) begin
              a_mag          <= apply_sign(display_output, display_output[WIDTH-1]);
              a_neg          <= display_output[WIDTH-1];
              b_mag          <= '0;
              b_neg          <= 1'b0;
              op             <= op_in;
              display_output <= '0;
              complete       <= 1'b0;
              state          <= ENTRY_B;
            end else if (digit_valid) begin
              a_mag          <= digit_ovf ? '0 : digit_mag;
              a_neg          <= 1'b0;
              b_mag          <= '0;
              b_neg          <= 1'b0;
              op             <= OP_NONE;
              overflow       <= digit_ovf;
              display_output <= digit_ovf ? '0 : digit_mag;
              complete       <= 1'b0;
              state          <= ENTRY_A;
            end
          end
          default: state <= ENTRY_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_core_p.sv
// Self-checking bench for calc_core_p: hand vectors, corner sequences and a
// randomized run against an arithmetic reference model (WIDTH=16 plus a WIDTH=8 copy).
module tb_calc_core_p;

  localparam int W  = 16;
  localparam int W8 = 8;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (W-1));
`ifdef CALC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nRST;
  logic [3:0]    keypad_input;
  logic          read_input, equal_input, negate_input, clear_input;
  logic [2:0]    operator_input;
  logic          complete, busy, overflow;
  logic [W-1:0]  display_output;
  logic          complete8, busy8, overflow8;
  logic [W8-1:0] display8;

  always #5 clk = ~clk;

  calc_core_p #(.WIDTH(W)) u_dut (
    .clk(clk), .nRST(nRST), .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input), .negate_input(negate_input),
    .clear_input(clear_input), .complete(complete), .busy(busy), .overflow(overflow),
    .display_output(display_output)
  );

  calc_core_p #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .nRST(nRST), .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input), .negate_input(negate_input),
    .clear_input(clear_input), .complete(complete8), .busy(busy8), .overflow(overflow8),
    .display_output(display8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint disp16();
    return longint'($signed(display_output));
  endfunction

  function automatic longint disp8();
    return longint'($signed(display8));
  endfunction

  // Reference model: operands as integer magnitude + sign, results by plain arithmetic.
  longint m_mag[2];
  bit     m_neg[2];
  int     m_sel;
  int     m_op;
  bit     m_ovf;
  bit     m_done;
  longint m_res;

  task automatic m_reset();
    m_mag[0] = 0; m_mag[1] = 0; m_neg[0] = 0; m_neg[1] = 0;
    m_sel = 0; m_op = 0; m_ovf = 0; m_done = 0; m_res = 0;
  endtask

  function automatic longint m_show();
    if (m_done) return m_res;
    return m_neg[m_sel] ? -m_mag[m_sel] : m_mag[m_sel];
  endfunction

  function automatic int oh2op(input logic [2:0] oh);
    case (oh)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic m_digit(input int d);
    longint nm;
    if (d > 9) return;
    if (m_done) begin
      m_reset();
    end
    nm = m_mag[m_sel] * 10 + d;
    if (nm > MAXV) m_ovf = 1;
    else m_mag[m_sel] = nm;
  endtask

  task automatic m_operator(input logic [2:0] oh);
    int o;
    o = oh2op(oh);
    if (o == 0) return;
    if (m_done) begin
      m_mag[0] = (m_res < 0) ? -m_res : m_res;
      m_neg[0] = (m_res < 0);
      m_done = 0;
    end else if (m_sel != 0) begin
      return;
    end
    m_op = o; m_sel = 1; m_mag[1] = 0; m_neg[1] = 0;
  endtask

  task automatic m_equal();
    longint a, b, x;
    a = m_neg[0] ? -m_mag[0] : m_mag[0];
    b = m_neg[1] ? -m_mag[1] : m_mag[1];
    case (m_op)
      1:       x = a + b;
      2:       x = a - b;
      default: x = a * b;
    endcase
    if (x > MAXV || x < MINV) begin
      m_ovf = 1;
      if (SAT) begin
        x = (x > MAXV) ? MAXV : MINV;
      end else begin
        x = x & ((64'sd1 <<< W) - 1);
        if (x > MAXV) x = x - (64'sd1 <<< W);
      end
    end
    m_res = x; m_done = 1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press_digit(input int d);
    keypad_input = 4'(d);
    read_input = 1'b1;
    m_digit(d);
    tick();
    check("digit display", disp16(), m_show());
    check("digit overflow", overflow, m_ovf);
    check("digit complete", complete, m_done);
    read_input = 1'b0;
    tick();
  endtask

  task automatic press_neg();
    negate_input = 1'b1;
    if (!m_done) m_neg[m_sel] = !m_neg[m_sel];
    tick();
    check("negate display", disp16(), m_show());
    negate_input = 1'b0;
    tick();
  endtask

  task automatic press_op(input logic [2:0] oh);
    operator_input = oh;
    m_operator(oh);
    tick();
    check("operator display", disp16(), m_show());
    operator_input = 3'b000;
    tick();
  endtask

  task automatic clear_all();
    clear_input = 1'b1;
    tick();
    clear_input = 1'b0;
    m_reset();
    check("clear display", disp16(), 0);
    check("clear complete", complete, 0);
    check("clear busy", busy, 0);
    check("clear overflow", overflow, 0);
  endtask

  task automatic press_equal(output int lat);
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
    check("busy after equal", busy, 1);
    lat = 1;
    while (!complete && lat < 100) begin
      tick();
      lat++;
    end
    m_equal();
    check("equal latency", lat, (m_op == 3) ? W + 1 : 2);
    check("result display", disp16(), m_res);
    check("result overflow", overflow, m_ovf);
    check("result busy", busy, 0);
  endtask

  task automatic enter_number(input int v);
    int q[$];
    while (v > 0) begin
      q.push_front(v % 10);
      v = v / 10;
    end
    foreach (q[i]) press_digit(q[i]);
  endtask

  typedef struct {
    int         a;
    bit         a_neg;
    logic [2:0] op;
    int         b;
    bit         b_neg;
    longint     exp_sat;
    longint     exp_wrap;
    bit         exp_ovf;
    int         exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    logic [2:0] ops[3];
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100;

    vecs[0]  = '{11,    0, 3'b001, 23,   0, 34,     34,     0, 2};
    vecs[1]  = '{4,     0, 3'b100, 3,    1, -12,    -12,    0, 17};
    vecs[2]  = '{200,   0, 3'b100, 200,  0, 32767,  -25536, 1, 17};
    vecs[3]  = '{15,    0, 3'b010, 40,   0, -25,    -25,    0, 2};
    vecs[4]  = '{5,     1, 3'b100, 6,    1, 30,     30,     0, 17};
    vecs[5]  = '{32767, 0, 3'b001, 1,    0, 32767,  -32768, 1, 2};
    vecs[6]  = '{32767, 1, 3'b010, 2,    0, -32768, 32767,  1, 2};
    vecs[7]  = '{7,     0, 3'b100, 0,    0, 0,      0,      0, 17};
    vecs[8]  = '{0,     1, 3'b001, 5,    0, 5,      5,      0, 2};
    vecs[9]  = '{128,   1, 3'b100, 256,  0, -32768, -32768, 0, 17};
    vecs[10] = '{182,   0, 3'b100, 182,  0, 32767,  -32412, 1, 17};
    vecs[11] = '{9999,  0, 3'b010, 9999, 1, 19998,  19998,  0, 2};

    nRST = 1'b0;
    keypad_input = 4'd0; read_input = 1'b0; operator_input = 3'b000;
    equal_input = 1'b0; negate_input = 1'b0; clear_input = 1'b0;
    m_reset();
    tick(); tick();
    check("reset display", disp16(), 0);
    check("reset complete", complete, 0);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    nRST = 1'b1;
    tick();
    check("post-reset display", disp16(), 0);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      clear_all();
      enter_number(vecs[i].a);
      if (vecs[i].a_neg) press_neg();
      press_op(vecs[i].op);
      enter_number(vecs[i].b);
      if (vecs[i].b_neg) press_neg();
      press_equal(lat);
      check($sformatf("vec%0d result", i), disp16(), SAT ? vecs[i].exp_sat : vecs[i].exp_wrap);
      check($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d complete", i), complete, 1);
    end

    // Entry saturation: the sixth digit is rejected
    clear_all();
    enter_number(32767);
    check("entry max display", disp16(), 32767);
    check("entry max overflow", overflow, 0);
    press_digit(1);
    check("entry reject display", disp16(), 32767);
    check("entry reject overflow", overflow, 1);

    // Clear five cycles into a multiply, then a fresh 2+3
    clear_all();
    enter_number(4);
    press_op(3'b100);
    enter_number(3);
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
    repeat (4) tick();
    check("mid-mul busy", busy, 1);
    clear_input = 1'b1;
    tick();
    clear_input = 1'b0;
    m_reset();
    check("abort busy", busy, 0);
    check("abort complete", complete, 0);
    check("abort display", disp16(), 0);
    check("abort overflow", overflow, 0);
    repeat (15) tick();
    check("abort no late complete", complete, 0);
    enter_number(2);
    press_op(3'b001);
    enter_number(3);
    press_equal(lat);
    check("after abort 2+3", disp16(), 5);

    // Equal held in DONE must not retrigger
    equal_input = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("held equal complete", complete, 1);
      check("held equal busy", busy, 0);
      check("held equal display", disp16(), 5);
    end
    equal_input = 1'b0;
    tick();

    // Operator level held in ENTRY_B is ignored; the latched op stands
    clear_all();
    enter_number(6);
    operator_input = 3'b100;
    m_operator(3'b100);
    tick();
    operator_input = 3'b001;
    m_operator(3'b001);
    tick(); tick();
    operator_input = 3'b000;
    tick();
    enter_number(7);
    press_equal(lat);
    check("held op result", disp16(), 42);
    check("held op latency", lat, W + 1);

    // Chain from the minimum value, then a new entry clears overflow
    clear_all();
    enter_number(128);
    press_neg();
    press_op(3'b100);
    enter_number(256);
    press_equal(lat);
    check("min result", disp16(), -32768);
    press_op(3'b010);
    check("chain display B", disp16(), 0);
    enter_number(1);
    press_equal(lat);
    check("chain min-1 result", disp16(), SAT ? -32768 : 32767);
    check("chain min-1 overflow", overflow, 1);
    press_digit(5);
    check("new entry display", disp16(), 5);
    check("new entry overflow", overflow, 0);
    check("new entry complete", complete, 0);
    press_digit(12);
    check("non-BCD ignored", disp16(), 5);

    // WIDTH=8 copy: 100+27 then chained +1
    clear_all();
    enter_number(100);
    press_op(3'b001);
    enter_number(27);
    press_equal(lat);
    check("w8 127 display", disp8(), 127);
    check("w8 127 overflow", overflow8, 0);
    check("w8 127 complete", complete8, 1);
    press_op(3'b001);
    enter_number(1);
    press_equal(lat);
    check("w8 128 display", disp8(), SAT ? 127 : -128);
    check("w8 128 overflow", overflow8, 1);
    check("w16 128 display", disp16(), 128);

    // Randomized sessions against the model
    for (int it = 0; it < 30; it++) begin
      int n;
      clear_all();
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) press_digit($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) press_neg();
      press_op(ops[$urandom_range(0, 2)]);
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) press_digit($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) press_neg();
      press_equal(lat);
      if ($urandom_range(0, 1) == 1) begin
        press_op(ops[$urandom_range(0, 2)]);
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) press_digit($urandom_range(0, 9));
        if ($urandom_range(0, 2) == 0) press_neg();
        press_equal(lat);
      end
      if ($urandom_range(0, 2) == 0) press_digit($urandom_range(0, 9));
    end

    // Asynchronous reset away from any clock edge
    clear_all();
    enter_number(7);
    press_op(3'b001);
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    check("async reset display", disp16(), 0);
    check("async reset complete", complete, 0);
    check("async reset busy", busy, 0);
    check("async reset overflow", overflow, 0);
    tick();
    nRST = 1'b1;
    m_reset();
    tick();
    press_digit(9);
    check("after async reset digit", disp16(), 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
